// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader feeding the instruction memory
// write port. Bytes arrive over a valid/ready handshake and are packed
// big-endian into 32-bit words. Each word's opcode field [31:26] is checked
// against the legal ISA opcode set. Legal words are written to sequential
// addresses. The core is held stalled until a terminator word arrives.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             single-cycle pulse that begins or restarts a session
//   in_data/in_valid  stream byte and its valid
//   in_ready          a byte is consumed when in_valid && in_ready
//   imem_we/addr/wdata instruction memory write port, one cycle per word
//   cpu_stall         holds core fetch/PC; low only in DONE
//   done / error      sticky session result, cleared by the next start
//   err_code          01 illegal opcode, 10 memory overflow
//   err_addr          word address at which the error was detected
//   word_count        words written this session
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LOAD  | accepting bytes of the current word
// WRITE | one cycle: classify the assembled word, write it if legal
// DONE  | terminator seen, core released
// ERROR | session aborted (illegal opcode or overflow), core held
module instr_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] TERM_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [31:0]         word_q;
  logic [1:0]          byte_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                full_q;
  logic [ADDR_W:0]     word_count_q;
  logic [1:0]          err_code_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic clear_session;
  logic load_byte;
  logic do_write;
  logic set_err_op;
  logic set_err_full;
  logic is_term;
  logic op_legal;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
      6'b001001, 6'b001010, 6'b001011, 6'b001100,
      6'b010001, 6'b010010, 6'b010011, 6'b010100,
      6'b011001, 6'b011010,
      6'b101001, 6'b101010, 6'b101011,
      6'b111000, 6'b111001, 6'b111010, 6'b111011,
      6'b111100, 6'b111101, 6'b111110: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign is_term  = (word_q == TERM_WORD);
  assign op_legal = opcode_legal(word_q[31:26]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    imem_we       = 1'b0;
    cpu_stall     = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    clear_session = 1'b0;
    load_byte     = 1'b0;
    do_write      = 1'b0;
    set_err_op    = 1'b0;
    set_err_full  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          clear_session = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Once the last address is used, any further byte means the
          // program does not fit, even if it would have been a terminator.
          if (full_q) begin
            state_d      = ERROR;
            set_err_full = 1'b1;
          end else begin
            load_byte = 1'b1;
            if (byte_cnt_q == 2'd3) begin
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (is_term) begin
          state_d = DONE;
        end else if (!op_legal) begin
          state_d    = ERROR;
          set_err_op = 1'b1;
        end else begin
          imem_we  = 1'b1;
          do_write = 1'b1;
          state_d  = LOAD;
        end
      end
      DONE: begin
        cpu_stall = 1'b0;
        done      = 1'b1;
        if (start) begin
          state_d       = LOAD;
          clear_session = 1'b1;
        end
      end
      ERROR: begin
        error = 1'b1;
        if (start) begin
          state_d       = LOAD;
          clear_session = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q       <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      full_q       <= 1'b0;
      word_count_q <= '0;
      err_code_q   <= '0;
      err_addr_q   <= '0;
    end else begin
      if (clear_session) begin
        word_q       <= '0;
        byte_cnt_q   <= '0;
        addr_q       <= '0;
        full_q       <= 1'b0;
        word_count_q <= '0;
        err_code_q   <= '0;
        err_addr_q   <= '0;
      end
      // Shifting left packs the first byte of a word into [31:24].
      if (load_byte) begin
        word_q     <= {word_q[23:0], in_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (do_write) begin
        word_count_q <= word_count_q + 1'b1;
        if (addr_q == ADDR_MAX) begin
          full_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
      if (set_err_op) begin
        err_code_q <= 2'b01;
        err_addr_q <= addr_q;
      end
      if (set_err_full) begin
        err_code_q <= 2'b10;
        err_addr_q <= ADDR_MAX;
      end
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign err_code   = err_code_q;
  assign err_addr   = err_addr_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed sessions from the test plan
// followed by randomized programs, all compared against a word-level model.
module tb_instr_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_stall;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;
  logic [AW:0]   word_count;

  instr_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  logic [5:0] legal_ops [25] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
    6'b001001, 6'b001010, 6'b001011, 6'b001100,
    6'b010001, 6'b010010, 6'b010011, 6'b010100,
    6'b011001, 6'b011010,
    6'b101001, 6'b101010, 6'b101011,
    6'b111000, 6'b111001, 6'b111010, 6'b111011, 6'b111100, 6'b111101, 6'b111110
  };

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Stimulus bytes for the session and the model's predictions.
  logic [7:0]  stim_q [$];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic [31:0] obs_addr_q [$];
  logic [31:0] obs_data_q [$];
  bit          e_done, e_err;
  int          e_code, e_eaddr, e_cnt;

  // Word-level reference: walk the byte list four at a time.
  task automatic model();
    int p;
    bit full;
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    e_done = 0; e_err = 0; e_code = 0; e_eaddr = 0; e_cnt = 0;
    full = 0;
    p = 0;
    while (p < stim_q.size()) begin
      if (full) begin
        e_err = 1; e_code = 2; e_eaddr = DEPTH - 1;
        break;
      end
      if (p + 4 > stim_q.size()) break;
      w = {stim_q[p], stim_q[p+1], stim_q[p+2], stim_q[p+3]};
      p += 4;
      if (w == 32'hFFFF_FFFF) begin
        e_done = 1;
        break;
      end
      if (!is_legal(w[31:26])) begin
        e_err = 1; e_code = 1; e_eaddr = e_cnt;
        break;
      end
      exp_addr_q.push_back(e_cnt);
      exp_data_q.push_back(w);
      if (e_cnt == DEPTH - 1) full = 1;
      e_cnt++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      obs_addr_q.push_back(32'(imem_addr));
      obs_data_q.push_back(imem_wdata);
      chk("ready_in_write", 32'(in_ready), 32'd0);
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
    int n;
    ok = 0;
    n = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && !done && !error && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      @(posedge clk);
      ok = 1;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_and_compare(input string name);
    int n;
    in_valid = 1'b0;
    n = 0;
    while (!(done || error) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ended"}, 32'(done || error), 32'd1);
    chk({name, "_done"}, 32'(done), 32'(e_done));
    chk({name, "_error"}, 32'(error), 32'(e_err));
    chk({name, "_err_code"}, 32'(err_code), 32'(e_code));
    chk({name, "_err_addr"}, 32'(err_addr), 32'(e_eaddr));
    chk({name, "_word_count"}, 32'(word_count), 32'(e_cnt));
    chk({name, "_cpu_stall"}, 32'(cpu_stall), 32'(!e_done));
    chk({name, "_nwrites"}, 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      chk({name, "_waddr"}, obs_addr_q[i], exp_addr_q[i]);
      chk({name, "_wdata"}, obs_data_q[i], exp_data_q[i]);
    end
  endtask

  task automatic run_session(input string name, input bit gaps, input bit do_start);
    bit ok;
    model();
    obs_addr_q.delete();
    obs_data_q.delete();
    if (do_start) pulse_start();
    foreach (stim_q[i]) begin
      if (done || error) break;
      send_byte(stim_q[i], gaps, ok);
      if (!ok) break;
    end
    finish_and_compare(name);
  endtask

  task automatic push_word(input logic [31:0] w);
    stim_q.push_back(w[31:24]);
    stim_q.push_back(w[23:16]);
    stim_q.push_back(w[15:8]);
    stim_q.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] op;
    if ($urandom_range(0, 99) < 85) op = legal_ops[$urandom_range(0, 24)];
    else op = 6'($urandom_range(0, 63));
    return {op, 26'($urandom)};
  endfunction

  task automatic check_reset_values(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({name, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({name, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({name, "_cpu_stall"}, 32'(cpu_stall), 32'd1);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_error"}, 32'(error), 32'd0);
    chk({name, "_err_code"}, 32'(err_code), 32'd0);
    chk({name, "_err_addr"}, 32'(err_addr), 32'd0);
    chk({name, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle");

    // Single ADDI then terminator.
    stim_q.delete();
    push_word(32'h0400_0005);
    push_word(32'hFFFF_FFFF);
    run_session("addi", 0, 1);
    if (obs_data_q.size() > 0) chk("addi_value", obs_data_q[0], 32'h0400_0005);

    // Three words with idle cycles between bytes.
    stim_q.delete();
    push_word(32'h0800_1234);
    push_word(32'h2400_5678);
    push_word(32'hE000_9ABC);
    push_word(32'hFFFF_FFFF);
    run_session("gaps", 1, 1);

    // Illegal opcode 001111 as the second word.
    stim_q.delete();
    push_word(32'h0400_0001);
    push_word(32'h3C00_0000);
    run_session("illegal", 0, 1);
    chk("illegal_err_addr_abs", 32'(err_addr), 32'd1);

    // Fill memory, then one more byte overflows.
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) push_word({legal_ops[i % 25], 26'(i * 7 + 3)});
    stim_q.push_back(8'hFF);
    run_session("overflow", 0, 1);
    chk("overflow_code_abs", 32'(err_code), 32'd2);
    chk("overflow_count_abs", 32'(word_count), 32'(DEPTH));

    // Reset after two bytes of a word.
    pulse_start();
    send_byte(8'h04, 0, ok);
    send_byte(8'h00, 0, ok);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    stim_q.delete();
    push_word(32'h0C00_00AA);
    push_word(32'hFFFF_FFFF);
    run_session("after_rst", 0, 1);

    // start mid-word is ignored; partial word kept.
    stim_q.delete();
    push_word(32'h0800_0001);
    push_word(32'hFFFF_FFFF);
    model();
    obs_addr_q.delete();
    obs_data_q.delete();
    pulse_start();
    send_byte(stim_q[0], 0, ok);
    send_byte(stim_q[1], 0, ok);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < stim_q.size(); i++) begin
      if (done || error) break;
      send_byte(stim_q[i], 0, ok);
      if (!ok) break;
    end
    finish_and_compare("midstart");

    // start in DONE restarts with a cleared session.
    pulse_start();
    chk("restart_word_count", 32'(word_count), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    stim_q.delete();
    push_word(32'hA400_0042);
    push_word(32'hFFFF_FFFF);
    run_session("restart", 0, 0);

    // Randomized programs.
    for (int s = 0; s < 40; s++) begin
      stim_q.delete();
      if ($urandom_range(0, 9) == 0) begin
        n = DEPTH + 1;
        for (int i = 0; i < n; i++) push_word(rand_word());
      end else begin
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) push_word(rand_word());
        push_word(32'hFFFF_FFFF);
      end
      run_session("rand", s[0], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
